// File: rtl/amo_exec_unit.sv
// RV32A word atomic executor: one load, ALU combine, one store, then returns the
// original memory word. Misaligned requests answer immediately with an error.
module amo_exec_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_amoop,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_data,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   old_q, old_d;
  logic [XLEN-1:0]   new_q, new_d;
  logic              err_q, err_d;

  // Unlisted encodings (9-15) fall through to ADD, as the decoder does.
  function automatic logic [XLEN-1:0] amo_alu(input logic [3:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic [XLEN-1:0]        res;
    sa = a;
    sb = b;
    case (op)
      4'd1:    res = b;
      4'd2:    res = a ^ b;
      4'd3:    res = a & b;
      4'd4:    res = a | b;
      4'd5:    res = (sb < sa) ? b : a;
      4'd6:    res = (sb > sa) ? b : a;
      4'd7:    res = (b < a) ? b : a;
      4'd8:    res = (b > a) ? b : a;
      default: res = a + b;
    endcase
    return res;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      b_q     <= '0;
      old_q   <= '0;
      new_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      b_q     <= b_d;
      old_q   <= old_d;
      new_q   <= new_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    b_d           = b_q;
    old_d         = old_q;
    new_d         = new_q;
    err_d         = err_q;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    mem_be        = 4'h0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = req_amoop;
          addr_d  = req_addr;
          b_d     = req_data;
          old_d   = '0;
          err_d   = |req_addr[1:0];
          state_d = (|req_addr[1:0]) ? RESP : RD_REQ;
        end
      end
      RD_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = RD_WAIT;
      end
      // rvalid is only looked at here, so one coincident with the read handshake is dropped.
      RD_WAIT: begin
        if (mem_rvalid) begin
          old_d   = mem_rdata;
          new_d   = amo_alu(op_q, mem_rdata, b_q);
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        mem_req_valid = 1'b1;
        mem_we        = 1'b1;
        mem_be        = 4'hF;
        if (mem_req_ready) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = new_q;
  assign rsp_rdata = (state_q == RESP && !err_q) ? old_q : '0;
  assign rsp_err   = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_amo_exec_unit.sv
// Directed bench for amo_exec_unit with a word-memory responder and response/store scoreboards.
module tb_amo_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_amoop;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  amo_exec_unit #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_amoop(req_amoop),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] rdata; logic err; } rsp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } st_t;

  rsp_t        exp_rsp[$];
  st_t         exp_st[$];
  logic [31:0] mem [int];

  int n_cmp = 0;
  int n_err = 0;
  int ready_delay = 0;
  bit drop_rvalid = 1'b0;
  int rd_cnt = 0;
  int st_cnt = 0;
  int we_cnt = 0;
  int mreq_cnt = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (mem_we === 1'b1) we_cnt <= we_cnt + 1;
    if (mem_req_valid === 1'b1) mreq_cnt <= mreq_cnt + 1;
  end

  // Memory responder: ready after ready_delay stall cycles, rvalid one cycle after a read handshake.
  initial begin
    int          stall_cnt;
    bit          pending_rd;
    logic [31:0] pend_addr;
    logic [64:0] snap;
    st_t         e;
    stall_cnt = 0;
    pending_rd = 1'b0;
    pend_addr = '0;
    snap = '0;
    mem_req_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_req_ready = 1'b0;
        mem_rvalid = 1'b0;
        pending_rd = 1'b0;
        stall_cnt = 0;
      end else begin
        mem_rvalid = 1'b0;
        if (pending_rd) begin
          if (!drop_rvalid) begin
            mem_rvalid = 1'b1;
            mem_rdata = mem[pend_addr];
          end
          pending_rd = 1'b0;
        end
        if (mem_req_valid) begin
          if (stall_cnt == 0) snap = {mem_we, mem_addr, mem_wdata};
          else chk("req_stable", {31'd0, mem_we, mem_addr, mem_wdata}, {31'd0, snap});
          if (stall_cnt < ready_delay) begin
            mem_req_ready = 1'b0;
            stall_cnt++;
          end else begin
            mem_req_ready = 1'b1;
            stall_cnt = 0;
            if (mem_we) begin
              st_cnt++;
              chk("store_be", mem_be, 4'hF);
              if (exp_st.size() == 0) begin
                chk("unexpected_store", mem_wdata, 32'h0BAD0BAD);
              end else begin
                e = exp_st.pop_front();
                chk("store_addr", mem_addr, e.addr);
                chk("store_data", mem_wdata, e.data);
              end
              mem[mem_addr] = mem_wdata;
            end else begin
              rd_cnt++;
              pending_rd = 1'b1;
              pend_addr = mem_addr;
            end
          end
        end else begin
          mem_req_ready = 1'b0;
          stall_cnt = 0;
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data);
    int guard;
    req_amoop = op;
    req_addr = addr;
    req_data = data;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("req_accept", req_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    @(negedge clk);
    cyc = 1;
    while (!rsp_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("rsp_seen", rsp_valid, 1'b1);
  endtask

  // Runs one AMO; exp_lat of 0 skips the latency check.
  task automatic do_amo(input string tag, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] b, input bit set_mem, input logic [31:0] init,
                        input logic [31:0] exp_old, input logic [31:0] exp_store, input int exp_lat);
    rsp_t r;
    st_t  s;
    int   cyc;
    if (set_mem) mem[addr] = init;
    r.rdata = exp_old;
    r.err = 1'b0;
    exp_rsp.push_back(r);
    s.addr = addr;
    s.data = exp_store;
    exp_st.push_back(s);
    issue(op, addr, b);
    wait_rsp(cyc);
    r = exp_rsp.pop_front();
    chk({tag, "_rdata"}, rsp_rdata, r.rdata);
    chk({tag, "_err"}, rsp_err, r.err);
    if (exp_lat > 0) chk({tag, "_latency"}, cyc, exp_lat);
    @(negedge clk);
    chk({tag, "_single_pulse"}, rsp_valid, 1'b0);
    chk({tag, "_ready_after"}, req_ready, 1'b1);
  endtask

  initial begin
    rsp_t r;
    int   cyc;
    int   base;
    int   guard;
    rst = 1'b1;
    req_valid = 1'b0;
    req_amoop = '0;
    req_addr = '0;
    req_data = '0;
    #1;
    chk("reset_outputs",
        {req_ready, rsp_valid, rsp_err, mem_req_valid, mem_we, mem_be, rsp_rdata, mem_addr, mem_wdata},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_amo("add", 4'd0, 32'h100, 32'h1, 1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 4);
    do_amo("min", 4'd5, 32'h104, 32'h1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4);
    do_amo("minu", 4'd7, 32'h108, 32'h1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4);
    do_amo("max", 4'd6, 32'h118, 32'h5, 1'b1, 32'h80000000, 32'h80000000, 32'h00000005, 4);
    do_amo("op12_add", 4'd12, 32'h114, 32'h7, 1'b1, 32'h5, 32'h5, 32'hC, 4);

    ready_delay = 5;
    do_amo("swap_stall", 4'd1, 32'h10C, 32'hDEADBEEF, 1'b1, 32'h12345678, 32'h12345678, 32'hDEADBEEF, 0);
    do_amo("maxu_stall", 4'd8, 32'h110, 32'h7FFFFFFF, 1'b1, 32'h80000000, 32'h80000000, 32'h80000000, 0);
    ready_delay = 0;

    base = mreq_cnt;
    r.rdata = 32'h0;
    r.err = 1'b1;
    exp_rsp.push_back(r);
    issue(4'd4, 32'h102, 32'hFFFF0000);
    wait_rsp(cyc);
    r = exp_rsp.pop_front();
    chk("misal_latency", cyc, 1);
    chk("misal_err", rsp_err, r.err);
    chk("misal_rdata", rsp_rdata, r.rdata);
    @(negedge clk);
    chk("misal_single_pulse", rsp_valid, 1'b0);
    chk("misal_no_mem_req", mreq_cnt, base);

    // Abort while waiting for read data.
    mem[32'h200] = 32'h11111111;
    drop_rvalid = 1'b1;
    base = rd_cnt;
    issue(4'd0, 32'h200, 32'h1);
    guard = 0;
    while (rd_cnt == base && guard < 50) begin
      @(negedge clk);
      #1 guard++;
    end
    chk("abort_read_issued", rd_cnt, base + 1);
    @(negedge clk);
    base = we_cnt;
    #1 rst = 1'b1;
    #1;
    chk("abort_outputs",
        {req_ready, rsp_valid, rsp_err, mem_req_valid, mem_we, mem_be, rsp_rdata, mem_addr, mem_wdata},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0});
    @(negedge clk);
    rst = 1'b0;
    drop_rvalid = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_store", we_cnt, base);
    chk("abort_mem_intact", mem[32'h200], 32'h11111111);
    do_amo("post_reset_add", 4'd0, 32'h204, 32'h10, 1'b1, 32'h20, 32'h20, 32'h30, 4);

    do_amo("b2b_xor", 4'd2, 32'h300, 32'hFF00FF00, 1'b1, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h0FF00FF0, 4);
    do_amo("b2b_and", 4'd3, 32'h300, 32'h0FFFFFFF, 1'b0, 32'h0, 32'h0FF00FF0, 32'h0FF00FF0, 4);

    chk("store_queue_drained", exp_st.size(), 0);
    chk("mem_final", mem[32'h300], 32'h0FF00FF0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/amo_exec_unit.md
Name: amo_exec_unit

Overview:
- Executes RV32A word atomics (AMO*.W) that the decode stage classifies into the 4-bit amoop_t encoding.
- Sits between the execute/memory stage and the data-memory port.
- Performs an atomic read-modify-write: one load, ALU combine, one store.
- Returns the original memory word for rd; the pipeline stalls while the unit is busy.

Parameters:
- XLEN, 32, data and address width.
- ADDR_W, 32, memory address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  AMO request from pipeline
- req_ready  out  1  unit idle, request accepted when req_valid&&req_ready
- req_amoop  in  4  amoop_t: 0 ADD, 1 SWAP, 2 XOR, 3 AND, 4 OR, 5 MIN, 6 MAX, 7 MINU, 8 MAXU
- req_addr  in  ADDR_W  rs1 address
- req_data  in  XLEN  rs2 operand
- rsp_valid  out  1  one-cycle pulse, result available
- rsp_rdata  out  XLEN  original memory word (rd value)
- rsp_err  out  1  misaligned address, no memory access made
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  1 = store, 0 = load
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  XLEN  store data
- mem_be  out  4  byte enables, always 4'b1111 when mem_we
- mem_rvalid  in  1  load data valid
- mem_rdata  in  XLEN  load data

Behaviour:
- Reset (async, rst=1): state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_req_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0.
- FSM states and transitions:
  - IDLE: on accept, latch amoop/addr/data. If addr[1:0]!=0 go to RESP with err=1; otherwise go to RD_REQ.
  - RD_REQ: mem_req_valid=1, mem_we=0. On mem_req_ready go to RD_WAIT.
  - RD_WAIT: on mem_rvalid, latch old=mem_rdata, compute new, go to WR_REQ. If mem_rvalid arrives in the same cycle as the RD_REQ handshake, it is ignored; rvalid must come at least 1 cycle later.
  - WR_REQ: mem_req_valid=1, mem_we=1, mem_wdata=new, mem_be=4'hF. On mem_req_ready go to RESP. A store completes on handshake; there is no write response.
  - RESP: rsp_valid=1 for exactly one cycle, rsp_rdata=old (0 when err), rsp_err as latched. Then go to IDLE.
- req_ready=1 only in IDLE. A back-to-back request can be accepted the cycle after RESP.
- mem_req_valid, mem_we, mem_addr and mem_wdata hold stable while valid && !ready.
- Minimum latency, accept to rsp_valid: 4 cycles, with ready and rvalid 1 cycle after each request. Misaligned requests: 1 cycle.
- Compute rules (a = old memory word, b = latched rs2), all 32-bit, wrap-around add:
  - ADD a+b; SWAP b; XOR a^b; AND a&b; OR a|b.
  - MIN/MAX use signed compare; MINU/MAXU use unsigned compare.
  - Equal operands return a.
  - Encodings 9–15 behave as ADD, matching the decoder default.
- Reset mid-operation aborts immediately; no store is issued after reset deasserts.

Test Plan:
- ADD: mem[0x100]=0x7FFFFFFF, rs2=1, addr 0x100 -> store 0x80000000, rsp_rdata=0x7FFFFFFF, rsp_err=0.
- MIN vs MINU: mem=0xFFFFFFFF, rs2=0x00000001. MIN stores 0xFFFFFFFF; MINU stores 0x00000001. Both return 0xFFFFFFFF.
- SWAP/MAXU with mem_req_ready held low 5 cycles per request -> request signals stable throughout, single rsp_valid pulse, rsp_rdata correct.
- Misaligned addr 0x102, AMOOR -> no mem_req_valid ever, rsp_valid and rsp_err=1 one cycle after accept.
- Reset asserted in RD_WAIT -> all outputs return to reset values asynchronously, mem_we never asserted, next request executes normally.
- Back-to-back: AMOXOR then AMOAND to the same address, mem=0xF0F0F0F0, rs2 0xFF00FF00 then 0x0FFFFFFF. First store is 0x0FF00FF0; second returns 0x0FF00FF0 and stores 0x0FF00FF0.
